// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM transaction controller: FSM state
// encodings, operation codes, database geometry and power-on account tables.
package atm_pkg;

  localparam int NUM_ACCOUNTS   = 10;
  localparam int TIMEOUT_CYCLES = 5;

  localparam int ACC_W = 4;
  localparam int PIN_W = 16;
  localparam int BAL_W = 32;
  localparam int OP_W  = 3;

  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(NUM_ACCOUNTS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd7,
    ST_AUTH = 3'd1,
    ST_MENU = 3'd2,
    ST_EXEC = 3'd3
  } state_t;

  localparam logic [OP_W-1:0] OP_BALANCE    = 3'd3;
  localparam logic [OP_W-1:0] OP_WITHDRAW   = 3'd4;
  localparam logic [OP_W-1:0] OP_DEPOSIT    = 3'd5;
  localparam logic [OP_W-1:0] OP_CHANGE_PIN = 3'd6;

  localparam logic [PIN_W-1:0] PIN_MIN = 16'd1000;
  localparam logic [PIN_W-1:0] PIN_MAX = 16'd9999;

  // Entry i belongs to account i+1.
  localparam logic [PIN_W-1:0] INIT_PIN [NUM_ACCOUNTS] = '{
    16'd1234, 16'd2345, 16'd3456, 16'd4567, 16'd5678,
    16'd6789, 16'd7890, 16'd8901, 16'd9012, 16'd7123
  };

  localparam logic [BAL_W-1:0] INIT_BAL [NUM_ACCOUNTS] = '{
    32'd1000, 32'd2000, 32'd3000, 32'd4000, 32'd5000,
    32'd6000, 32'd7000, 32'd8000, 32'd9000, 32'd10000
  };

endpackage

// File: rtl/atm_account_db.sv
// Account register file: per-account PIN and balance, one combinational read
// port, one write port (PIN or balance), synchronous reset to the initial tables.
module atm_account_db
  import atm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] rd_idx,
  output logic [PIN_W-1:0] rd_pin,
  output logic [BAL_W-1:0] rd_bal,
  input  logic             wr_en,
  input  logic             wr_pin_sel,
  input  logic [ACC_W-1:0] wr_idx,
  input  logic [PIN_W-1:0] wr_pin,
  input  logic [BAL_W-1:0] wr_bal
);

  logic [PIN_W-1:0] pin_q [NUM_ACCOUNTS];
  logic [BAL_W-1:0] bal_q [NUM_ACCOUNTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        pin_q[i] <= INIT_PIN[i];
        bal_q[i] <= INIT_BAL[i];
      end
    end else if (wr_en && (wr_idx < ACC_MAX)) begin
      if (wr_pin_sel) pin_q[wr_idx] <= wr_pin;
      else            bal_q[wr_idx] <= wr_bal;
    end
  end

  // Out-of-range indices read as zero so the caller never sees a stray entry.
  always_comb begin
    rd_pin = '0;
    rd_bal = '0;
    if (rd_idx < ACC_MAX) begin
      rd_pin = pin_q[rd_idx];
      rd_bal = bal_q[rd_idx];
    end
  end

endmodule

// File: rtl/atm.sv
// Single-session ATM transaction controller: IDLE -> AUTH -> MENU -> EXEC -> IDLE.
// Optional macro ATM_TIMEOUT_EN: MENU waits up to TIMEOUT_CYCLES for a valid operation.
module atm
  import atm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  operation,
  input  logic [ACC_W-1:0] acc_num,
  input  logic [PIN_W-1:0] pin,
  input  logic [PIN_W-1:0] newPin,
  input  logic [BAL_W-1:0] amount,
  input  logic             language,
  output logic [BAL_W-1:0] balance,
  output logic             success,
  output logic [2:0]       state
);

  function automatic logic [BAL_W:0] add_ext(input logic [BAL_W-1:0] a,
                                             input logic [BAL_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic pin_acceptable(input logic [PIN_W-1:0] cand,
                                          input logic [PIN_W-1:0] cur);
    return (cand != cur) && (cand >= PIN_MIN) && (cand <= PIN_MAX);
  endfunction

  state_t           state_q, state_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic             success_q, success_d;

  logic [ACC_W-1:0] acc_idx;
  logic             acc_ok;
  logic             op_valid;
  logic [PIN_W-1:0] db_pin;
  logic [BAL_W-1:0] db_bal;
  logic [BAL_W:0]   dep_sum;

  logic             wr_en;
  logic             wr_pin_sel;
  logic [PIN_W-1:0] wr_pin;
  logic [BAL_W-1:0] wr_bal;

  // Message language only matters to the display side.
  logic unused_language;
  assign unused_language = language;

  assign acc_idx  = acc_num - ACC_W'(1);
  assign acc_ok   = (acc_num != '0) && (acc_num <= ACC_MAX);
  assign op_valid = (operation >= OP_BALANCE) && (operation <= OP_CHANGE_PIN);
  assign dep_sum  = add_ext(db_bal, amount);

  atm_account_db u_db (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (acc_idx),
    .rd_pin     (db_pin),
    .rd_bal     (db_bal),
    .wr_en      (wr_en),
    .wr_pin_sel (wr_pin_sel),
    .wr_idx     (acc_idx),
    .wr_pin     (wr_pin),
    .wr_bal     (wr_bal)
  );

`ifdef ATM_TIMEOUT_EN
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] tmo_q, tmo_d;

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      balance_q <= '0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      balance_q <= balance_d;
      success_q <= success_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    balance_d  = balance_q;
    success_d  = success_q;
    wr_en      = 1'b0;
    wr_pin_sel = 1'b0;
    wr_pin     = '0;
    wr_bal     = '0;
`ifdef ATM_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_AUTH;
      ST_AUTH: begin
`ifdef ATM_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (acc_ok && (pin == db_pin)) begin
          state_d = ST_MENU;
        end else begin
          state_d   = ST_IDLE;
          balance_d = '0;
          success_d = 1'b0;
        end
      end
      ST_MENU: begin
        if (op_valid) begin
          state_d = ST_EXEC;
        end else begin
`ifdef ATM_TIMEOUT_EN
          if (tmo_q == TMO_LAST) begin
            state_d   = ST_IDLE;
            success_d = 1'b0;
          end else begin
            tmo_d = tmo_q + 4'd1;
          end
`else
          state_d   = ST_IDLE;
          success_d = 1'b0;
`endif
        end
      end
      ST_EXEC: begin
        // Rejected operations still report the untouched balance.
        state_d   = ST_IDLE;
        balance_d = db_bal;
        success_d = 1'b0;
        case (operation)
          OP_BALANCE: success_d = 1'b1;
          OP_WITHDRAW: begin
            if (amount <= db_bal) begin
              wr_en     = 1'b1;
              wr_bal    = db_bal - amount;
              balance_d = db_bal - amount;
              success_d = 1'b1;
            end
          end
          OP_DEPOSIT: begin
            if (!dep_sum[BAL_W]) begin
              wr_en     = 1'b1;
              wr_bal    = dep_sum[BAL_W-1:0];
              balance_d = dep_sum[BAL_W-1:0];
              success_d = 1'b1;
            end
          end
          OP_CHANGE_PIN: begin
            if (pin_acceptable(newPin, db_pin)) begin
              wr_en      = 1'b1;
              wr_pin_sel = 1'b1;
              wr_pin     = newPin;
              success_d  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign balance = balance_q;
  assign success = success_q;
  assign state   = state_q;

endmodule

// File: tb/tb_atm.sv
// Directed self-checking bench for the atm transaction controller.
module tb_atm;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  operation;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] newPin;
  logic [31:0] amount;
  logic        language;
  logic [31:0] balance;
  logic        success;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  atm dut (
    .clk       (clk),
    .rst       (rst),
    .operation (operation),
    .acc_num   (acc_num),
    .pin       (pin),
    .newPin    (newPin),
    .amount    (amount),
    .language  (language),
    .balance   (balance),
    .success   (success),
    .state     (state)
  );

  always #5 clk = ~clk;

`ifdef ATM_TIMEOUT_EN
  localparam int INV_EDGES = 7;
`else
  localparam int INV_EDGES = 3;
`endif

  localparam logic [15:0] INIT_PINS [10] = '{
    16'd1234, 16'd2345, 16'd3456, 16'd4567, 16'd5678,
    16'd6789, 16'd7890, 16'd8901, 16'd9012, 16'd7123
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one transaction from IDLE and wait (bounded) for the return to IDLE.
  task automatic txn(input string tag, input logic [3:0] a, input logic [15:0] p,
                     input logic [2:0] op, input logic [31:0] amt, input logic [15:0] np,
                     input int exp_edges, input logic chk_bal, input logic [31:0] exp_bal,
                     input logic exp_suc);
    int n;
    acc_num   = a;
    pin       = p;
    operation = op;
    amount    = amt;
    newPin    = np;
    language  = ~language;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (state !== 3'd7 && n < 20);
    chk({tag, ".edges"}, 32'(n), 32'(exp_edges));
    if (chk_bal) chk({tag, ".balance"}, balance, exp_bal);
    chk({tag, ".success"}, {31'd0, success}, {31'd0, exp_suc});
  endtask

  initial begin
    rst = 1'b1; operation = 3'd0; acc_num = 4'd0; pin = 16'd0;
    newPin = 16'd0; amount = 32'd0; language = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.state", {29'd0, state}, 32'd7);
    chk("reset.balance", balance, 32'd0);
    chk("reset.success", {31'd0, success}, 32'd0);

    for (int k = 1; k <= 10; k++)
      txn($sformatf("inq%0d", k), 4'(k), INIT_PINS[k-1], 3'd3, 32'd0, 16'd0,
          4, 1'b1, 32'(1000 * k), 1'b1);

    for (int k = 1; k <= 10; k++)
      txn($sformatf("overdraw%0d", k), 4'(k), INIT_PINS[k-1], 3'd4, 32'(1000 * k + 100),
          16'd0, 4, 1'b1, 32'(1000 * k), 1'b0);

    for (int k = 1; k <= 10; k++) begin
      txn($sformatf("dep%0d", k), 4'(k), INIT_PINS[k-1], 3'd5, 32'd1000, 16'd0,
          4, 1'b1, 32'(1000 * k + 1000), 1'b1);
      txn($sformatf("wd%0d", k), 4'(k), INIT_PINS[k-1], 3'd4, 32'd500, 16'd0,
          4, 1'b1, 32'(1000 * k + 500), 1'b1);
    end

    for (int a = 11; a <= 15; a++)
      txn($sformatf("badacc%0d", a), 4'(a), 16'd1234, 3'd3, 32'd0, 16'd0,
          2, 1'b1, 32'd0, 1'b0);
    txn("badacc0", 4'd0, 16'd1234, 3'd3, 32'd0, 16'd0, 2, 1'b1, 32'd0, 1'b0);
    txn("setbal", 4'd3, 16'd3456, 3'd3, 32'd0, 16'd0, 4, 1'b1, 32'd3500, 1'b1);
    txn("badpin", 4'd3, 16'd3457, 3'd3, 32'd0, 16'd0, 2, 1'b1, 32'd0, 1'b0);

    txn("pin_same", 4'd2, 16'd2345, 3'd6, 32'd0, 16'd2345, 4, 1'b0, 32'd0, 1'b0);
    txn("pin_low", 4'd2, 16'd2345, 3'd6, 32'd0, 16'd999, 4, 1'b0, 32'd0, 1'b0);
    txn("pin_high", 4'd2, 16'd2345, 3'd6, 32'd0, 16'd10000, 4, 1'b0, 32'd0, 1'b0);
    txn("pin_chg", 4'd1, 16'd1234, 3'd6, 32'd0, 16'd5678, 4, 1'b1, 32'd1500, 1'b1);
    txn("pin_old", 4'd1, 16'd1234, 3'd3, 32'd0, 16'd0, 2, 1'b1, 32'd0, 1'b0);
    txn("pin_new", 4'd1, 16'd5678, 3'd3, 32'd0, 16'd0, 4, 1'b1, 32'd1500, 1'b1);

    txn("inv7", 4'd4, 16'd4567, 3'd7, 32'd0, 16'd0, INV_EDGES, 1'b1, 32'd1500, 1'b0);
    txn("inq4", 4'd4, 16'd4567, 3'd3, 32'd0, 16'd0, 4, 1'b1, 32'd4500, 1'b1);
    txn("inv0", 4'd4, 16'd4567, 3'd0, 32'd0, 16'd0, INV_EDGES, 1'b1, 32'd4500, 1'b0);

    txn("dep_ovf", 4'd5, 16'd5678, 3'd5, 32'hFFFF_FFFF - 32'd5500 + 32'd1, 16'd0,
        4, 1'b1, 32'd5500, 1'b0);
    txn("dep_max", 4'd5, 16'd5678, 3'd5, 32'hFFFF_FFFF - 32'd5500, 16'd0,
        4, 1'b1, 32'hFFFF_FFFF, 1'b1);
    txn("wd_all", 4'd5, 16'd5678, 3'd4, 32'hFFFF_FFFF, 16'd0, 4, 1'b1, 32'd0, 1'b1);

    // Reset lands on the edge that would leave EXEC; nothing may commit.
    acc_num = 4'd6; pin = 16'd6789; operation = 3'd5; amount = 32'd77;
    repeat (3) @(posedge clk);
    #1;
    chk("mid.exec", {29'd0, state}, 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid.state", {29'd0, state}, 32'd7);
    chk("mid.balance", balance, 32'd0);
    chk("mid.success", {31'd0, success}, 32'd0);
    txn("post_inq6", 4'd6, 16'd6789, 3'd3, 32'd0, 16'd0, 4, 1'b1, 32'd6000, 1'b1);
    txn("post_pin1", 4'd1, 16'd1234, 3'd3, 32'd0, 16'd0, 4, 1'b1, 32'd1000, 1'b1);
    txn("post_bb", 4'd10, 16'd7123, 3'd3, 32'd0, 16'd0, 4, 1'b1, 32'd10000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
